rgb_fade_sequencer: RTL
=======================

// Module: rgb_fade_sequencer
// PURPOSE
//  Controller that sits between the three encoder level registers and the three pwm channels.
//  - Manual mode: passes the encoder levels straight through.
//  - Auto mode: plays a stored sequence of RGB presets. It holds each preset, then fades
//    linearly to the next one, one LSB per tick.
//  - Presets are captured from the live encoder values.
// PARAMETERS
//  NUM_PRESETS  4    preset slots; power of 2; index width PW = $clog2(NUM_PRESETS)
//  STEP_DIV     256  clk cycles per fade/hold tick (>=2)
//  HOLD_TICKS   64   ticks spent on each preset before fading to the next (>=1)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   reset; asynchronous, active-low
//  auto_en      in   1   1 = auto sequence, 0 = manual pass-through (level)
//  capture      in   1   1-cycle strobe; store enc0..2 into preset[capture_idx]
//  capture_idx  in   PW  destination slot for capture
//  enc0         in   8   encoder level, red
//  enc1         in   8   encoder level, green
//  enc2         in   8   encoder level, blue
//  level0       out  8   level to pwm0
//  level1       out  8   level to pwm1
//  level2       out  8   level to pwm2
//  preset_idx   out  PW  current target preset
//  fading       out  1   1 while in FADE state
// BEHAVIOUR
//  Reset values: all presets, level0..2, preset_idx, fading, prescaler and hold counter = 0; state = MANUAL.
//  All outputs are registered.
//  FSM states: MANUAL, FADE, HOLD.
//  - MANUAL: levelN <= encN every cycle (1-cycle latency). Prescaler is held at 0.
//    auto_en==1 -> FADE with preset_idx = 0; levels start from their current values.
//  - FADE: on each tick, each channel steps 1 toward preset[preset_idx][ch].
//    - Channels move independently; a channel already at its target stays put.
//    - When all three equal their targets (checked every cycle, including the entry cycle)
//      -> HOLD and clear the hold counter.
//  - HOLD: levels are frozen. The hold counter increments on each tick.
//    When it reaches HOLD_TICKS -> FADE with preset_idx <= preset_idx+1, wrapping at NUM_PRESETS-1 -> 0.
//  - auto_en==0 in FADE or HOLD -> MANUAL next cycle; levels resume tracking encN.
//  Tick: 1-cycle pulse when the prescaler equals STEP_DIV-1. The prescaler then wraps to 0.
//    It runs only in FADE and HOLD.
//  Capture:
//    - Accepted in any state; the write takes effect on the next clk edge.
//    - In FADE, the target is read live from the preset array: a capture into preset_idx
//      retargets the fade from the following cycle. Levels never jump.
//    - In HOLD, a capture into preset_idx does not change the levels until the next FADE.
//  Arithmetic: levels are unsigned 8 bit. A step never overshoots its target, so no wrap is possible.
//  Reset mid-fade: asynchronous return to the reset values; the preset contents are lost.
// CONFIGURATION
//  `RGB_SEQ_GAMMA_EN defined:
//    - levelN outputs carry (lin*lin)>>8 of the internal linear level, registered in the same stage.
//      0->0, 128->64, 255->254.
//    - Gamma is applied in all states, including MANUAL. Latency is unchanged.
//  `RGB_SEQ_GAMMA_EN undefined: levelN = internal linear level; no multiplier is instantiated.
// STRUCTURE
//  - Shared package rgb_mixer_pkg: LEVEL_W=8, the rgb_t typedef (3 x LEVEL_W), and the
//    state encoding localparams ST_MANUAL/ST_FADE/ST_HOLD.
//  - One sub-module: rgb_tick_gen (parameter DIV; inputs clk, reset, run; output tick).
//    It is the prescaler, and is reusable for the pwm clock divide.
//  - The step-toward-target logic is a function, not a module.
// TESTING
//  T1 Reset: assert reset mid-cycle -> levels=0, fading=0, preset_idx=0 immediately (async).
//  T2 Manual: auto_en=0, enc0/1/2=8'h10/8'h80/8'hFF -> level0/1/2 match one cycle later.
//  T3 Fade: STEP_DIV=4, HOLD_TICKS=2, preset0={5,0,3}, levels start at 0, auto_en=1.
//     -> level0 reaches 5 after 5 ticks (20 clk) and level2 stops at 3 after 3 ticks.
//     -> fading drops the cycle after level0 reaches 5.
//  T4 Hold/wrap: NUM_PRESETS=4, run through all presets.
//     -> after 2 ticks in HOLD on preset 3, preset_idx=0 and fading=1.
//  T5 Retarget: during a fade toward level0=200, capture enc0=50 into preset_idx while level0=100.
//     -> level0 decrements toward 50 with no jump.
//  T6 Exit: drop auto_en mid-fade -> next cycle state=MANUAL; levels = encN one cycle later.
//     Repeat T2 and T3 with RGB_SEQ_GAMMA_EN defined: 128 -> 64.

Source files
------------

// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer blocks: level width, the packed
// three-channel colour type, FSM state encoding and small per-channel helpers.
package rgb_mixer_pkg;

    localparam int LEVEL_W = 8;

    // Index 0 = red, 1 = green, 2 = blue.
    typedef logic [2:0][LEVEL_W-1:0] rgb_t;

    localparam logic [1:0] ST_MANUAL = 2'd0;
    localparam logic [1:0] ST_FADE   = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    typedef enum logic [1:0] {
        MANUAL = ST_MANUAL,
        FADE   = ST_FADE,
        HOLD   = ST_HOLD
    } state_t;

    // Move one LSB toward the target; equal levels stay put, so no overshoot or wrap.
    function automatic logic [LEVEL_W-1:0] step_toward(input logic [LEVEL_W-1:0] cur,
                                                      input logic [LEVEL_W-1:0] tgt);
        if (cur < tgt)
            return cur + 1'b1;
        else if (cur > tgt)
            return cur - 1'b1;
        else
            return cur;
    endfunction

`ifdef RGB_SEQ_GAMMA_EN
    // Square-law perceptual correction: (lin*lin)>>8.
    function automatic logic [LEVEL_W-1:0] gamma_sq(input logic [LEVEL_W-1:0] lin);
        logic [2*LEVEL_W-1:0] sq;
        sq = lin * lin;
        return sq[2*LEVEL_W-1:LEVEL_W];
    endfunction
`endif

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Control/level bundle between the encoder registers, the fade sequencer and the pwm channels.
interface rgb_fade_sequencer_if #(
    parameter int PW = 2
);
    import rgb_mixer_pkg::*;

    logic               auto_en;
    logic               capture;
    logic [PW-1:0]      capture_idx;
    logic [LEVEL_W-1:0] enc0;
    logic [LEVEL_W-1:0] enc1;
    logic [LEVEL_W-1:0] enc2;
    logic [LEVEL_W-1:0] level0;
    logic [LEVEL_W-1:0] level1;
    logic [LEVEL_W-1:0] level2;
    logic [PW-1:0]      preset_idx;
    logic               fading;

    modport master (
        output auto_en, capture, capture_idx, enc0, enc1, enc2,
        input  level0, level1, level2, preset_idx, fading
    );

    modport slave (
        input  auto_en, capture, capture_idx, enc0, enc1, enc2,
        output level0, level1, level2, preset_idx, fading
    );

endinterface

// File: rtl/rgb_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks while run is high,
// counter parked at zero otherwise. Also usable as the pwm clock divider.
module rgb_tick_gen #(
    parameter int DIV = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int          CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Count 0..DIV-1 while running, hold at zero when stopped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_reg <= '0;
        else if (!run || cnt_reg == LAST)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign tick = run && (cnt_reg == LAST);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: manual pass-through of encoder levels, or automatic
// playback of captured presets with hold periods and linear one-LSB-per-tick fades.
// Optional build macro RGB_SEQ_GAMMA_EN adds square-law gamma on the level outputs.
module rgb_fade_sequencer
    import rgb_mixer_pkg::*;
#(
    parameter int NUM_PRESETS = 4,
    parameter int STEP_DIV    = 256,
    parameter int HOLD_TICKS  = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    rgb_fade_sequencer_if.slave  bus
);

    localparam int PW = $clog2(NUM_PRESETS);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_t        state_reg, state_next;
    rgb_t          lin_reg, lin_next;
    logic [PW-1:0] idx_reg, idx_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic          fading_reg;
    rgb_t          preset_mem [NUM_PRESETS];

    rgb_t enc_vec;
    rgb_t target;
    rgb_t stepped;
    rgb_t out_vec;
    logic at_target;
    logic tick;
    logic run;

    assign enc_vec   = {bus.enc2, bus.enc1, bus.enc0};
    // Target is read live so a capture into the active slot retargets an ongoing fade.
    assign target    = preset_mem[idx_reg];
    assign at_target = (lin_reg == target);
    assign run       = (state_reg == FADE) || (state_reg == HOLD);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_step
            assign stepped[gi] = step_toward(lin_reg[gi], target[gi]);
        end
    endgenerate

    rgb_tick_gen #(
        .DIV (STEP_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    // Next-state and datapath update for the MANUAL/FADE/HOLD sequencer.
    always_comb begin
        state_next = state_reg;
        lin_next   = lin_reg;
        idx_next   = idx_reg;
        hold_next  = hold_reg;
        case (state_reg)
            MANUAL: begin
                lin_next = enc_vec;
                if (bus.auto_en) begin
                    state_next = FADE;
                    idx_next   = '0;
                end
            end
            FADE: begin
                if (!bus.auto_en) begin
                    state_next = MANUAL;
                end else if (at_target) begin
                    state_next = HOLD;
                    hold_next  = '0;
                end else if (tick) begin
                    lin_next = stepped;
                end
            end
            HOLD: begin
                if (!bus.auto_en) begin
                    state_next = MANUAL;
                end else if (tick) begin
                    if (hold_reg == HOLD_LAST) begin
                        state_next = FADE;
                        idx_next   = idx_reg + 1'b1;
                        hold_next  = '0;
                    end else begin
                        hold_next = hold_reg + 1'b1;
                    end
                end
            end
            default: state_next = MANUAL;
        endcase
    end

    // Sequencer state, linear levels, preset index and hold counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= MANUAL;
            lin_reg    <= '0;
            idx_reg    <= '0;
            hold_reg   <= '0;
            fading_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lin_reg    <= lin_next;
            idx_reg    <= idx_next;
            hold_reg   <= hold_next;
            fading_reg <= (state_next == FADE);
        end
    end

    // Preset store: cleared on reset, written from the live encoders on a capture strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PRESETS; i++)
                preset_mem[i] <= '0;
        end else if (bus.capture) begin
            preset_mem[bus.capture_idx] <= enc_vec;
        end
    end

`ifdef RGB_SEQ_GAMMA_EN
    rgb_t gam_next;
    rgb_t level_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_gamma
            assign gam_next[gi] = gamma_sq(lin_next[gi]);
        end
    endgenerate

    // Gamma-corrected copy registered alongside the linear level, so latency is unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            level_reg <= '0;
        else
            level_reg <= gam_next;
    end

    assign out_vec = level_reg;
`else
    assign out_vec = lin_reg;
`endif

    assign bus.level0     = out_vec[0];
    assign bus.level1     = out_vec[1];
    assign bus.level2     = out_vec[2];
    assign bus.preset_idx = idx_reg;
    assign bus.fading     = fading_reg;

endmodule
